// File: rtl/mem_access_pkg.sv
// Shared types and constants for the memory-access driver slice.
package mem_access_pkg;

    localparam int unsigned MEM_DATA_W = 32;
    localparam int unsigned MEM_CTRL_W = 17;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef struct packed {
        logic [MEM_DATA_W-1:0] addr;
        logic [MEM_DATA_W-1:0] data;
        logic [MEM_CTRL_W-1:0] ctrl;
    } mem_req_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        STALL
    } drv_state_e;

endpackage

// File: rtl/mem_req_fifo.sv
// Request FIFO for the memory-access driver; DEPTH must be a power of two so the
// pointers wrap naturally.
module mem_req_fifo
    import mem_access_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type         T     = mem_req_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  T                       wr_data,
    input  logic                   pop,
    output T                       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    T             mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);

endmodule

// File: rtl/mem_access_driver.sv
// Memory-access driver: buffers requests, issues them on the addr/data AXI-stream
// channels and returns results in order. Define MEM_DRV_STATS_EN for load/store counters.
module mem_access_driver
    import mem_access_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned CTRL_WIDTH      = 17,
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    input  logic [CTRL_WIDTH-1:0] req_ctrl,
    output logic [CTRL_WIDTH-1:0] ctrl_data_o,
    output logic                  axis_m_addr_tvalid,
    input  logic                  axis_m_addr_tready,
    output logic [DATA_WIDTH-1:0] axis_m_addr_tdata,
    output logic                  axis_m_data_tvalid,
    input  logic                  axis_m_data_tready,
    output logic [DATA_WIDTH-1:0] axis_m_data_tdata,
    input  logic                  axis_s_rslt_tvalid,
    output logic                  axis_s_rslt_tready,
    input  logic [DATA_WIDTH-1:0] axis_s_rslt_tdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data
`ifdef MEM_DRV_STATS_EN
    ,
    output logic [15:0]           stat_load_cnt,
    output logic [15:0]           stat_store_cnt
`endif
);

    localparam int unsigned CW      = $clog2(DEPTH);
    localparam logic [3:0]  MAX_OUT = 4'(MAX_OUTSTANDING);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic [CTRL_WIDTH-1:0] ctrl;
    } req_t;

    req_t       wr_req;
    req_t       head;
    logic       fifo_full;
    logic       fifo_empty;
    logic [CW:0] fifo_count;
    logic [CW:0] count_nxt;
    logic       push;
    logic       pop;
    logic       ready_en;

    drv_state_e state;
    drv_state_e state_d;
    logic       addr_done;
    logic       data_done;
    logic       addr_hs;
    logic       data_hs;
    logic       rslt_hs;
    logic       both_done;
    logic [3:0] outstanding;
    logic [3:0] outstanding_d;

    assign wr_req = '{addr: req_addr, data: req_data, ctrl: req_ctrl};

    mem_req_fifo #(
        .DEPTH (DEPTH),
        .T     (req_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (wr_req),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Holds req_ready low until the first clock edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ready_en <= 1'b0;
        else
            ready_en <= 1'b1;
    end

    assign req_ready = ready_en & ~fifo_full;
    assign push      = req_valid & req_ready;

    assign axis_m_addr_tdata = fifo_empty ? '0 : head.addr;
    assign axis_m_data_tdata = fifo_empty ? '0 : head.data;
    assign ctrl_data_o       = fifo_empty ? '0 : head.ctrl;

    always_comb begin
        axis_m_addr_tvalid = (state == ISSUE) && !addr_done;
        axis_m_data_tvalid = (state == ISSUE) && !data_done;
        addr_hs            = axis_m_addr_tvalid & axis_m_addr_tready;
        data_hs            = axis_m_data_tvalid & axis_m_data_tready;
        both_done          = (addr_done | addr_hs) & (data_done | data_hs);
        pop                = (state == ISSUE) & both_done;
        axis_s_rslt_tready = !rsp_valid | rsp_ready;
        rslt_hs            = axis_s_rslt_tvalid & axis_s_rslt_tready;

        // A stray result with nothing outstanding saturates at zero.
        outstanding_d = outstanding;
        if (pop && !rslt_hs)
            outstanding_d = outstanding + 4'd1;
        else if (!pop && rslt_hs && (outstanding != '0))
            outstanding_d = outstanding - 4'd1;

        count_nxt = fifo_count;
        case ({push, pop})
            2'b10:   count_nxt = fifo_count + 1'b1;
            2'b01:   count_nxt = fifo_count - 1'b1;
            default: ;
        endcase

        // Decide from next-cycle occupancy so a fresh entry issues one cycle after its write.
        if ((state == ISSUE) && !pop)
            state_d = ISSUE;
        else if (count_nxt == '0)
            state_d = IDLE;
        else if (outstanding_d < MAX_OUT)
            state_d = ISSUE;
        else
            state_d = STALL;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            addr_done   <= 1'b0;
            data_done   <= 1'b0;
            outstanding <= '0;
        end else begin
            state       <= state_d;
            outstanding <= outstanding_d;
            if (pop) begin
                addr_done <= 1'b0;
                data_done <= 1'b0;
            end else begin
                if (addr_hs)
                    addr_done <= 1'b1;
                if (data_hs)
                    data_done <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else if (rslt_hs) begin
            rsp_valid <= 1'b1;
            rsp_data  <= axis_s_rslt_tdata;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

`ifdef MEM_DRV_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_load_cnt  <= '0;
            stat_store_cnt <= '0;
        end else if (pop) begin
            if (head.ctrl[6:0] == OPC_LOAD)
                stat_load_cnt <= stat_load_cnt + 16'd1;
            if (head.ctrl[6:0] == OPC_STORE)
                stat_store_cnt <= stat_store_cnt + 16'd1;
        end
    end
`endif

endmodule
